// File: rtl/mem_arbiter.sv
// Round-robin owner of the single memory port, shared between
// instruction fetch (I) and data access (D).
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WRITEDATA,
  input  logic [DATA_W-1:0] M_READDATA,
  input  logic              M_BUSYWAIT,
  output logic [1:0]        GRANT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  // owner/last: 1 = D port, 0 = I port
  logic owner;
  logic last;
  logic i_req;
  logic d_req;
  logic start;
  logic pick_d;
  logic done;
  logic fin;
  logic resp;

  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;
  assign resp  = (state == S_RESP);

  assign I_BUSYWAIT = i_req & ~(resp & ~owner);
  assign D_BUSYWAIT = d_req & ~(resp & owner);

  always_ff @(posedge CLK) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    pick_d    = 1'b0;
    done      = 1'b0;
    fin       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_req | d_req) begin
          start     = 1'b1;
          // on contention the port that went last loses
          pick_d    = d_req & (~i_req | ~last);
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (!M_BUSYWAIT) begin
          done      = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        fin       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      owner       <= 1'b0;
      last        <= 1'b0;
      GRANT       <= 2'b00;
      M_READ      <= 1'b0;
      M_WRITE     <= 1'b0;
      M_ADDR      <= '0;
      M_WRITEDATA <= '0;
      I_READDATA  <= '0;
      D_READDATA  <= '0;
    end else begin
      if (start) begin
        owner   <= pick_d;
        GRANT   <= pick_d ? 2'b10 : 2'b01;
        M_WRITE <= pick_d & D_WRITE;
        M_READ  <= ~(pick_d & D_WRITE);
        M_ADDR  <= pick_d ? D_ADDR : I_ADDR;
        if (pick_d) M_WRITEDATA <= D_WRITEDATA;
      end
      if (done) begin
        M_READ  <= 1'b0;
        M_WRITE <= 1'b0;
        if (M_READ & owner)  D_READDATA <= M_READDATA;
        if (M_READ & ~owner) I_READDATA <= M_READDATA;
      end
      if (fin) begin
        last  <= owner;
        GRANT <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model plus directed
// scenarios, then randomized traffic with random memory stalls.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_read;
  logic [9:0]  i_addr;
  logic [31:0] i_rdata;
  logic        i_bw;
  logic        d_read;
  logic        d_write;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_bw;
  logic        m_read;
  logic        m_write;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_busy;
  logic [1:0]  grant;

  mem_arbiter dut (
    .CLK(clk), .RESET(rst),
    .I_READ(i_read), .I_ADDR(i_addr),
    .I_READDATA(i_rdata), .I_BUSYWAIT(i_bw),
    .D_READ(d_read), .D_WRITE(d_write), .D_ADDR(d_addr),
    .D_WRITEDATA(d_wdata), .D_READDATA(d_rdata),
    .D_BUSYWAIT(d_bw),
    .M_READ(m_read), .M_WRITE(m_write), .M_ADDR(m_addr),
    .M_WRITEDATA(m_wdata), .M_READDATA(m_rdata),
    .M_BUSYWAIT(m_busy), .GRANT(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit check_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Transaction-level model: a grant holds the port for one issue
  // cycle, then until memory is ready (checked from the 2nd edge
  // after the grant), then one response cycle.
  bit          m_act, m_done, m_own, m_last;
  int          m_age;
  logic        x_rd, x_wr;
  logic [9:0]  x_addr;
  logic [31:0] x_wd, x_ird, x_drd;
  logic [1:0]  x_gnt;

  task automatic model_step();
    if (!rst) begin
      m_act = 0; m_done = 0; m_own = 0; m_last = 0; m_age = 0;
      x_rd = 0; x_wr = 0; x_addr = 0; x_wd = 0;
      x_gnt = 0; x_ird = 0; x_drd = 0;
    end else if (!m_act) begin
      if (i_read || d_read || d_write) begin
        m_own  = (d_read || d_write) && (!i_read || !m_last);
        m_act  = 1; m_done = 0; m_age = 0;
        x_gnt  = m_own ? 2'b10 : 2'b01;
        x_wr   = m_own && d_write;
        x_rd   = !x_wr;
        x_addr = m_own ? d_addr : i_addr;
        if (m_own) x_wd = d_wdata;
      end
    end else begin
      m_age++;
      if (m_done) begin
        m_act = 0; m_last = m_own; x_gnt = 0;
      end else if (m_age >= 2 && !m_busy) begin
        if (x_rd) begin
          if (m_own) x_drd = m_rdata;
          else       x_ird = m_rdata;
        end
        x_rd = 0; x_wr = 0; m_done = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      automatic bit rsp = m_act && m_done;
      chk("grant", 32'(grant), 32'(x_gnt));
      chk("m_read", 32'(m_read), 32'(x_rd));
      chk("m_write", 32'(m_write), 32'(x_wr));
      chk("m_addr", 32'(m_addr), 32'(x_addr));
      if (x_wr) chk("m_wdata", m_wdata, x_wd);
      chk("i_rdata", i_rdata, x_ird);
      chk("d_rdata", d_rdata, x_drd);
      chk("i_bw", 32'(i_bw), 32'(i_read && !(rsp && !m_own)));
      chk("d_bw", 32'(d_bw),
          32'((d_read || d_write) && !(rsp && m_own)));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [1:0] seq [4];
  int         nseq;
  logic [1:0] prev;

  initial begin
    rst = 0; i_read = 1; i_addr = 10'h010;
    d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
    m_rdata = 32'hDEADBEEF; m_busy = 0;

    // reset held with a pending I request
    step();
    check_en = 1;
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_m_read", 32'(m_read), 32'h0);
    chk("rst_m_addr", 32'(m_addr), 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_i_bw", 32'(i_bw), 32'h1);

    // zero-wait I read
    rst = 1;
    step();
    chk("i_e0_grant", 32'(grant), 32'h1);
    chk("i_e0_mread", 32'(m_read), 32'h1);
    chk("i_e0_maddr", 32'(m_addr), 32'h010);
    step();
    chk("i_e1_mread", 32'(m_read), 32'h1);
    chk("i_e1_bw", 32'(i_bw), 32'h1);
    step();
    chk("i_e2_mread", 32'(m_read), 32'h0);
    chk("i_e2_rdata", i_rdata, 32'hDEADBEEF);
    chk("i_e2_bw", 32'(i_bw), 32'h0);
    step();
    chk("i_e3_grant", 32'(grant), 32'h0);
    chk("i_e3_bw", 32'(i_bw), 32'h1);
    i_read = 0;

    // D write with 5 busy memory cycles
    d_write = 1; d_addr = 10'h3FC; d_wdata = 32'h12345678; m_busy = 1;
    step();
    chk("w_grant", 32'(grant), 32'h2);
    chk("w_mwrite", 32'(m_write), 32'h1);
    chk("w_mread", 32'(m_read), 32'h0);
    chk("w_maddr", 32'(m_addr), 32'h3FC);
    chk("w_mwdata", m_wdata, 32'h12345678);
    d_addr = 0; d_wdata = 0;
    repeat (6) begin
      step();
      chk("w_hold_mwrite", 32'(m_write), 32'h1);
      chk("w_hold_maddr", 32'(m_addr), 32'h3FC);
      chk("w_hold_mwdata", m_wdata, 32'h12345678);
    end
    m_busy = 0;
    step();
    chk("w_resp_mwrite", 32'(m_write), 32'h0);
    chk("w_resp_dbw", 32'(d_bw), 32'h0);
    chk("w_resp_drdata", d_rdata, 32'h0);
    step();
    chk("w_idle_grant", 32'(grant), 32'h0);
    d_write = 0;

    // continuous contention from reset release
    rst = 0;
    step();
    rst = 1; i_read = 1; d_read = 1; d_addr = 10'h100;
    nseq = 0; prev = 0;
    foreach (seq[k]) seq[k] = 0;
    repeat (30) begin
      step();
      if (grant != 0 && prev == 0 && nseq < 4) begin
        seq[nseq] = grant;
        nseq++;
      end
      prev = grant;
    end
    chk("rr_count", 32'(nseq), 32'd4);
    chk("rr_g0", 32'(seq[0]), 32'h2);
    chk("rr_g1", 32'(seq[1]), 32'h1);
    chk("rr_g2", 32'(seq[2]), 32'h2);
    chk("rr_g3", 32'(seq[3]), 32'h1);

    // reset during WAIT of a D read
    i_read = 0; d_read = 0;
    repeat (5) step();
    d_read = 1; d_addr = 10'h020; m_busy = 1;
    step();
    step();
    step();
    chk("rw_grant", 32'(grant), 32'h2);
    chk("rw_mread", 32'(m_read), 32'h1);
    rst = 0;
    step();
    chk("rw_mread0", 32'(m_read), 32'h0);
    chk("rw_grant0", 32'(grant), 32'h0);
    chk("rw_drdata0", d_rdata, 32'h0);
    rst = 1; d_read = 0; i_read = 1; i_addr = 10'h044;
    m_busy = 0; m_rdata = 32'h0BADF00D;
    step();
    chk("rw_i_e0_grant", 32'(grant), 32'h1);
    chk("rw_i_e0_bw", 32'(i_bw), 32'h1);
    step();
    chk("rw_i_e1_bw", 32'(i_bw), 32'h1);
    step();
    chk("rw_i_e2_bw", 32'(i_bw), 32'h0);
    chk("rw_i_e2_rdata", i_rdata, 32'h0BADF00D);
    step();
    i_read = 0;

    // D read withdrawn mid-WAIT with I pending
    d_read = 1; d_addr = 10'h0C0; m_busy = 1; m_rdata = 32'hCAFEF00D;
    step();
    chk("wd_grant", 32'(grant), 32'h2);
    i_read = 1;
    step();
    step();
    d_read = 0;
    step();
    m_busy = 0;
    step();
    chk("wd_resp_grant", 32'(grant), 32'h2);
    chk("wd_drdata", d_rdata, 32'hCAFEF00D);
    chk("wd_ibw", 32'(i_bw), 32'h1);
    step();
    chk("wd_idle_grant", 32'(grant), 32'h0);
    step();
    chk("wd_next_grant", 32'(grant), 32'h1);
    repeat (3) step();
    i_read = 0;
    step();

    // randomized traffic
    repeat (3000) begin
      step();
      rst     = ($urandom_range(0, 199) != 0);
      i_read  = ($urandom_range(0, 99) < 60);
      d_read  = ($urandom_range(0, 99) < 40);
      d_write = ($urandom_range(0, 99) < 30);
      i_addr  = 10'($urandom);
      d_addr  = 10'($urandom);
      d_wdata = $urandom;
      m_rdata = $urandom;
      m_busy  = ($urandom_range(0, 3) < 2);
    end
    rst = 1; i_read = 0; d_read = 0; d_write = 0; m_busy = 0;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one main-memory port between the CPU instruction-fetch path (I) and the data-access path (D).
- Serialises requests with a 4-state FSM and round-robin arbitration, and drives the memory read/write/busywait handshake.
- Returns read data and a per-port BUSYWAIT stall signal to each requester.
- Sits between the CPU (or its caches) and the single shared memory model.

Parameters:
ADDR_W, 10, memory byte-address width (1 KB space)
DATA_W, 32, word width of all data buses

Ports:
CLK  in  1  system clock; all state updates on posedge
RESET  in  1  synchronous, active-low reset (RESET=0 at a posedge resets)
I_READ  in  1  instruction read request, held until I_BUSYWAIT=0
I_ADDR  in  ADDR_W  instruction address
I_READDATA  out  DATA_W  registered instruction word
I_BUSYWAIT  out  1  stall to I requester
D_READ  in  1  data read request
D_WRITE  in  1  data write request
D_ADDR  in  ADDR_W  data address
D_WRITEDATA  in  DATA_W  write data
D_READDATA  out  DATA_W  registered read data
D_BUSYWAIT  out  1  stall to D requester
M_READ  out  1  memory read strobe (registered)
M_WRITE  out  1  memory write strobe (registered)
M_ADDR  out  ADDR_W  memory address (registered)
M_WRITEDATA  out  DATA_W  memory write data (registered)
M_READDATA  in  DATA_W  memory read data
M_BUSYWAIT  in  1  memory busy; 0 means the access is complete
GRANT  out  2  current owner: 00 none, 01 I, 10 D

Behaviour:
- Reset (RESET=0 at a posedge):
  - State goes to IDLE.
  - All registered outputs clear: M_READ, M_WRITE, M_ADDR, M_WRITEDATA, I_READDATA, D_READDATA and GRANT all become 0.
  - LAST flag becomes I, so D wins the first contention.
  - Reset has priority over every other event, including mid-transaction. An aborted memory access is simply dropped.
- States: IDLE, ISSUE, WAIT, RESP. An OWNER register records which port (I or D) holds the grant.
- IDLE:
  - D request is D_READ|D_WRITE; I request is I_READ.
  - On a posedge with any request: latch owner, address, op and write data into M_*, drive GRANT, and go to ISSUE.
  - Contention (both requesting): grant the port that is not LAST. Otherwise grant the sole requester.
  - If D_READ and D_WRITE are both set, treat the access as a write.
- ISSUE: M_READ/M_WRITE asserted. M_BUSYWAIT is ignored in this state. Go to WAIT unconditionally.
- WAIT:
  - M_* are held stable.
  - At a posedge with M_BUSYWAIT=0: on a read, latch M_READDATA into the owner's READDATA register; deassert M_READ/M_WRITE; go to RESP.
  - Otherwise stay in WAIT. There is no timeout.
- RESP:
  - The owner's BUSYWAIT is 0 for exactly this cycle.
  - At the next posedge: update LAST to OWNER, clear GRANT, go to IDLE.
  - A new request is not arbitrated until IDLE.
- BUSYWAIT (combinational):
  - I_BUSYWAIT = I_READ & !(state==RESP & OWNER==I).
  - D_BUSYWAIT = (D_READ|D_WRITE) & !(state==RESP & OWNER==D).
  - A port with no request always sees 0.
- Latency with a zero-wait memory: request sampled at edge E0 → ISSUE; E1 → WAIT; E2 → RESP; the requester completes at E3. Each extra busy cycle of memory adds one cycle.
- Writes leave D_READDATA unchanged.
- Request withdrawn mid-transaction: the memory access still completes through RESP, and READDATA is still updated. This is not an error.
- Requesters must hold address and data stable while BUSYWAIT=1. Changes during that window are ignored because the values were latched in IDLE.

Test Plan:
1. Hold RESET=0 for 2 edges with I_READ=1 → all registered outputs 0, GRANT=00, I_BUSYWAIT=1. Release RESET → I is served normally.
2. I_READ with I_ADDR=0x010, M_BUSYWAIT always 0, M_READDATA=32'hDEADBEEF → M_READ high for exactly E0–E2, M_ADDR=0x010, I_READDATA=DEADBEEF after E2, I_BUSYWAIT=0 for exactly one cycle.
3. D_WRITE with D_ADDR=0x3FC, D_WRITEDATA=0x12345678, memory busy 5 cycles → M_WRITE/M_ADDR/M_WRITEDATA stable through all WAIT cycles, deasserted in RESP, D_READDATA unchanged.
4. I_READ and D_READ held continuously from reset release → grants alternate D,I,D,I (GRANT 10,01,10,01). Each requester stalls until its own RESP.
5. RESET=0 during WAIT of a D read → next edge M_READ=0, GRANT=00, D_READDATA=0. A subsequent I_READ completes with the nominal 3-cycle latency.
6. D_READ dropped during WAIT (M_READDATA=0xCAFEF00D) → the FSM still passes through RESP, D_READDATA=CAFEF00D, and a pending I_READ is granted at the next IDLE.
